// File: rtl/reg_check_sequencer_if.sv
// Control, configuration, regfile-port and result bundle of the register self-check sequencer.
// The master side drives start/configuration and the regfile read data; the slave is the sequencer.
interface reg_check_sequencer_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic            start;
   logic            cfg_we;
   logic [AW-1:0]   cfg_addr;
   logic [XLEN+6:0] cfg_data;
   logic [4:0]      rf_raddr;
   logic [XLEN-1:0] rf_rdata;
   logic            busy;
   logic            done;
   logic            pass;
   logic            fail;
   logic            timeout;
   logic [AW-1:0]   fail_index;
   logic [XLEN-1:0] fail_got;
   logic [XLEN-1:0] fail_expected;
   logic [AW:0]     pass_count;

   modport master (
      output start, cfg_we, cfg_addr, cfg_data, rf_rdata,
      input  rf_raddr, busy, done, pass, fail, timeout,
             fail_index, fail_got, fail_expected, pass_count
   );

   modport slave (
      input  start, cfg_we, cfg_addr, cfg_data, rf_rdata,
      output rf_raddr, busy, done, pass, fail, timeout,
             fail_index, fail_got, fail_expected, pass_count
   );
endinterface

// File: rtl/reg_check_sequencer.sv
// Self-check engine: walks a programmable table of WAIT/CHECK register steps on a spare
// regfile read port and reports pass/fail with the failing step, observed and expected value.
module reg_check_sequencer #(
   parameter int XLEN      = 32,
   parameter int DEPTH     = 16,
   parameter int TIMEOUT   = 1000000,
   parameter int TIMEOUT_W = 32
) (
   input logic                  clk,
   input logic                  rst_n,
   reg_check_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = XLEN + 7;
   localparam bit TO_EN = (TIMEOUT != 0);
   localparam logic [TIMEOUT_W-1:0] TO_LAST = TO_EN ? TIMEOUT_W'(TIMEOUT - 1) : {TIMEOUT_W{1'b0}};
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
   localparam logic [1:0] OP_WAIT  = 2'd0;
   localparam logic [1:0] OP_CHECK = 2'd1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_READ    = 2'd1,
      ST_COMPARE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   function automatic logic op_is_end(input logic [1:0] op);
      return op[1];
   endfunction

   state_t           r_state;
   state_t           w_state_nxt;
   logic [EW-1:0]    r_table [DEPTH];
   logic [AW-1:0]    r_ptr;
   logic [AW-1:0]    w_ptr_nxt;
   logic [TIMEOUT_W-1:0] r_timer;
   logic [TIMEOUT_W-1:0] w_timer_nxt;
   logic [4:0]       r_raddr;
   logic [4:0]       w_raddr_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             r_pass;
   logic             w_pass_nxt;
   logic             r_fail;
   logic             w_fail_nxt;
   logic             r_timeout;
   logic             w_timeout_nxt;
   logic [AW-1:0]    r_fail_index;
   logic [AW-1:0]    w_fail_index_nxt;
   logic [XLEN-1:0]  r_fail_got;
   logic [XLEN-1:0]  w_fail_got_nxt;
   logic [XLEN-1:0]  r_fail_exp;
   logic [XLEN-1:0]  w_fail_exp_nxt;
   logic [AW:0]      r_pass_count;
   logic [AW:0]      w_pass_count_nxt;

   logic [EW-1:0]    w_entry;
   logic [1:0]       w_op;
   logic [4:0]       w_reg;
   logic [XLEN-1:0]  w_value;
   logic             w_match;
   logic             w_to_hit;
   logic             w_running;

   assign w_entry   = r_table[r_ptr];
   assign w_op      = w_entry[XLEN+6:XLEN+5];
   assign w_reg     = w_entry[XLEN+4:XLEN];
   assign w_value   = w_entry[XLEN-1:0];
   assign w_match   = (bus.rf_rdata == w_value);
   assign w_to_hit  = TO_EN && (r_timer == TO_LAST);
   assign w_running = (r_state == ST_READ) || (r_state == ST_COMPARE);

   // Table storage survives reset, so it has no reset term; host writes are locked out mid-run
   always_ff @(posedge clk) begin
      if (bus.cfg_we && !w_running) begin
         r_table[bus.cfg_addr] <= bus.cfg_data;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, step pointer, poll timer and result fields
   always_comb begin
      w_state_nxt      = r_state;
      w_ptr_nxt        = r_ptr;
      w_timer_nxt      = r_timer;
      w_raddr_nxt      = r_raddr;
      w_busy_nxt       = r_busy;
      w_done_nxt       = r_done;
      w_pass_nxt       = r_pass;
      w_fail_nxt       = r_fail;
      w_timeout_nxt    = r_timeout;
      w_fail_index_nxt = r_fail_index;
      w_fail_got_nxt   = r_fail_got;
      w_fail_exp_nxt   = r_fail_exp;
      w_pass_count_nxt = r_pass_count;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               w_state_nxt      = ST_READ;
               w_ptr_nxt        = {AW{1'b0}};
               w_timer_nxt      = {TIMEOUT_W{1'b0}};
               w_busy_nxt       = 1'b1;
               w_done_nxt       = 1'b0;
               w_pass_nxt       = 1'b0;
               w_fail_nxt       = 1'b0;
               w_timeout_nxt    = 1'b0;
               w_fail_index_nxt = {AW{1'b0}};
               w_fail_got_nxt   = {XLEN{1'b0}};
               w_fail_exp_nxt   = {XLEN{1'b0}};
               w_pass_count_nxt = {(AW+1){1'b0}};
            end else begin
               w_busy_nxt = 1'b0;
            end
         end
         ST_READ: begin
            w_raddr_nxt = w_reg;
            if (op_is_end(w_op)) begin
               w_state_nxt = ST_DONE;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_pass_nxt  = 1'b1;
            end else begin
               w_state_nxt = ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            if (w_match) begin
               if (w_op == OP_CHECK) begin
                  w_pass_count_nxt = r_pass_count + {{AW{1'b0}}, 1'b1};
               end else begin
                  w_timer_nxt = {TIMEOUT_W{1'b0}};
               end
               // The last entry acts as an implicit END; the pointer never wraps
               if (r_ptr == LAST_IDX) begin
                  w_state_nxt = ST_DONE;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_pass_nxt  = 1'b1;
               end else begin
                  w_ptr_nxt   = r_ptr + {{(AW-1){1'b0}}, 1'b1};
                  w_state_nxt = ST_READ;
               end
            end else if ((w_op == OP_WAIT) && !w_to_hit) begin
               w_timer_nxt = r_timer + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
               w_state_nxt = ST_READ;
            end else begin
               w_state_nxt      = ST_DONE;
               w_busy_nxt       = 1'b0;
               w_done_nxt       = 1'b1;
               w_fail_nxt       = 1'b1;
               w_timeout_nxt    = (w_op == OP_WAIT);
               w_fail_index_nxt = r_ptr;
               w_fail_got_nxt   = bus.rf_rdata;
               w_fail_exp_nxt   = w_value;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // Datapath and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr        <= {AW{1'b0}};
         r_timer      <= {TIMEOUT_W{1'b0}};
         r_raddr      <= 5'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_fail       <= 1'b0;
         r_timeout    <= 1'b0;
         r_fail_index <= {AW{1'b0}};
         r_fail_got   <= {XLEN{1'b0}};
         r_fail_exp   <= {XLEN{1'b0}};
         r_pass_count <= {(AW+1){1'b0}};
      end else begin
         r_ptr        <= w_ptr_nxt;
         r_timer      <= w_timer_nxt;
         r_raddr      <= w_raddr_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_pass       <= w_pass_nxt;
         r_fail       <= w_fail_nxt;
         r_timeout    <= w_timeout_nxt;
         r_fail_index <= w_fail_index_nxt;
         r_fail_got   <= w_fail_got_nxt;
         r_fail_exp   <= w_fail_exp_nxt;
         r_pass_count <= w_pass_count_nxt;
      end
   end

   assign bus.rf_raddr      = r_raddr;
   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.pass          = r_pass;
   assign bus.fail          = r_fail;
   assign bus.timeout       = r_timeout;
   assign bus.fail_index    = r_fail_index;
   assign bus.fail_got      = r_fail_got;
   assign bus.fail_expected = r_fail_exp;
   assign bus.pass_count    = r_pass_count;
endmodule

// File: tb/tb_reg_check_sequencer.sv
// Directed bench for reg_check_sequencer: vector table of one-step programs plus
// hand-written multi-step, timeout, full-table and protocol sequences.
module tb_reg_check_sequencer;
   localparam int XLEN  = 32;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int BUDGET = 2000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_check_sequencer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus_a ();
   reg_check_sequencer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus_b ();

   logic [XLEN-1:0] rf_a [32];
   logic [XLEN-1:0] rf_b [32];
   assign bus_a.rf_rdata = rf_a[bus_a.rf_raddr];
   assign bus_b.rf_rdata = rf_b[bus_b.rf_raddr];

   reg_check_sequencer #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(10), .TIMEOUT_W(32)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a));
   reg_check_sequencer #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(0), .TIMEOUT_W(32)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b));

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic [1:0]  op;
      logic [4:0]  rg;
      logic [31:0] val;
      logic [31:0] rf_val;
      logic        e_pass;
      logic        e_fail;
      logic        e_to;
      logic [31:0] e_got;
      logic [31:0] e_exp;
      logic [31:0] e_pc;
      int          e_cyc;
   } vec_t;

   vec_t vecs [8];

   function automatic logic [XLEN+6:0] ent(input logic [1:0] op, input logic [4:0] rg,
                                           input logic [31:0] val);
      return {op, rg, val};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic wr_a(input int idx, input logic [XLEN+6:0] data);
      @(negedge clk);
      bus_a.cfg_we   = 1'b1;
      bus_a.cfg_addr = AW'(idx);
      bus_a.cfg_data = data;
      @(negedge clk);
      bus_a.cfg_we   = 1'b0;
   endtask

   // Pulse start (optionally with a same-edge write), then count edges until done.
   // At cycle inj_cyc a start pulse and a table write are injected mid-run.
   task automatic run_a(input logic with_wr, input int wr_idx, input logic [XLEN+6:0] wr_data,
                        input int inj_cyc, output int cyc);
      @(negedge clk);
      bus_a.start = 1'b1;
      if (with_wr) begin
         bus_a.cfg_we   = 1'b1;
         bus_a.cfg_addr = AW'(wr_idx);
         bus_a.cfg_data = wr_data;
      end else begin
         bus_a.cfg_we = 1'b0;
      end
      @(posedge clk);
      #1;
      bus_a.start  = 1'b0;
      bus_a.cfg_we = 1'b0;
      cyc = 0;
      while (bus_a.done !== 1'b1 && cyc < BUDGET) begin
         @(posedge clk);
         #1;
         cyc++;
         bus_a.start  = 1'b0;
         bus_a.cfg_we = 1'b0;
         if (cyc == inj_cyc) begin
            bus_a.start    = 1'b1;
            bus_a.cfg_we   = 1'b1;
            bus_a.cfg_addr = 4'd3;
            bus_a.cfg_data = ent(2'd1, 5'd4, 32'hDEAD);
         end
      end
      bus_a.start  = 1'b0;
      bus_a.cfg_we = 1'b0;
      if (bus_a.done !== 1'b1) begin
         n_total++;
         $display("FAIL done_wait: no done within %0d cycles", BUDGET);
      end
   endtask

   task automatic check_res(input string tag, input logic e_pass, input logic e_fail,
                            input logic e_to, input logic [31:0] e_idx, input logic [31:0] e_got,
                            input logic [31:0] e_exp, input logic [31:0] e_pc);
      chk({tag, "_done"}, 32'(bus_a.done), 32'(e_pass | e_fail));
      chk({tag, "_busy"}, 32'(bus_a.busy), 32'd0);
      chk({tag, "_pass"}, 32'(bus_a.pass), 32'(e_pass));
      chk({tag, "_fail"}, 32'(bus_a.fail), 32'(e_fail));
      chk({tag, "_timeout"}, 32'(bus_a.timeout), 32'(e_to));
      chk({tag, "_fail_index"}, 32'(bus_a.fail_index), e_idx);
      chk({tag, "_fail_got"}, bus_a.fail_got, e_got);
      chk({tag, "_fail_expected"}, bus_a.fail_expected, e_exp);
      chk({tag, "_pass_count"}, 32'(bus_a.pass_count), e_pc);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, 32'(bus_a.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus_a.done), 32'd0);
      chk({tag, "_pass"}, 32'(bus_a.pass), 32'd0);
      chk({tag, "_fail"}, 32'(bus_a.fail), 32'd0);
      chk({tag, "_timeout"}, 32'(bus_a.timeout), 32'd0);
      chk({tag, "_pass_count"}, 32'(bus_a.pass_count), 32'd0);
      chk({tag, "_rf_raddr"}, 32'(bus_a.rf_raddr), 32'd0);
      chk({tag, "_fail_got"}, bus_a.fail_got, 32'd0);
   endtask

   initial begin
      int cyc;
      bus_a.start = 1'b0; bus_a.cfg_we = 1'b0; bus_a.cfg_addr = 4'd0; bus_a.cfg_data = '0;
      bus_b.start = 1'b0; bus_b.cfg_we = 1'b0; bus_b.cfg_addr = 4'd0; bus_b.cfg_data = '0;
      for (int i = 0; i < 32; i++) begin
         rf_a[i] = 32'd0;
         rf_b[i] = 32'd0;
      end

      //               op    rg     val            rf_val         pass  fail  to    got            exp            pc     cyc
      vecs[0] = '{2'd1, 5'd5,  32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'd1, 3};
      vecs[1] = '{2'd1, 5'd5,  32'h0000_1234, 32'h0000_1235, 1'b0, 1'b1, 1'b0, 32'h0000_1235, 32'h0000_1234, 32'd0, 2};
      vecs[2] = '{2'd1, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'd1, 3};
      vecs[3] = '{2'd1, 5'd0,  32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'd1, 3};
      vecs[4] = '{2'd3, 5'd9,  32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'd0, 1};
      vecs[5] = '{2'd0, 5'd7,  32'h0000_0009, 32'h0000_0009, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'd0, 3};
      vecs[6] = '{2'd0, 5'd7,  32'h0000_0009, 32'h0000_0008, 1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'h0000_0009, 32'd0, 20};
      vecs[7] = '{2'd2, 5'd3,  32'h0000_0077, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'd0, 1};

      // Reset state
      #1;
      check_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Start together with the write of entry 0: the run must see the new entry
      wr_a(1, ent(2'd2, 5'd0, 32'd0));
      rf_a[0] = 32'd1;
      rf_a[1] = 32'h55;
      run_a(1'b1, 0, ent(2'd1, 5'd1, 32'h55), -1, cyc);
      chk("simul_wr_cycles", 32'(cyc), 32'd3);
      check_res("simul_wr", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd1);

      // One-step programs followed by END
      for (int v = 0; v < 8; v++) begin
         wr_a(0, ent(vecs[v].op, vecs[v].rg, vecs[v].val));
         wr_a(1, ent(2'd2, 5'd0, 32'd0));
         rf_a[vecs[v].rg] = vecs[v].rf_val;
         run_a(1'b0, 0, '0, -1, cyc);
         chk($sformatf("vec%0d_cycles", v), 32'(cyc), 32'(vecs[v].e_cyc));
         check_res($sformatf("vec%0d", v), vecs[v].e_pass, vecs[v].e_fail, vecs[v].e_to,
                   32'd0, vecs[v].e_got, vecs[v].e_exp, vecs[v].e_pc);
      end

      // WAIT then CHECK then END: done after 5 edges
      wr_a(0, ent(2'd0, 5'd20, 32'd1));
      wr_a(1, ent(2'd1, 5'd1, 32'd300));
      wr_a(2, ent(2'd2, 5'd0, 32'd0));
      rf_a[20] = 32'd1;
      rf_a[1]  = 32'd300;
      run_a(1'b0, 0, '0, -1, cyc);
      chk("passrun_cycles", 32'(cyc), 32'd5);
      check_res("passrun", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd1);

      // Third CHECK mismatches
      wr_a(0, ent(2'd1, 5'd1, 32'd10));
      wr_a(1, ent(2'd1, 5'd2, 32'd20));
      wr_a(2, ent(2'd1, 5'd3, 32'd30));
      wr_a(3, ent(2'd2, 5'd0, 32'd0));
      rf_a[1] = 32'd10; rf_a[2] = 32'd20; rf_a[3] = 32'd31;
      run_a(1'b0, 0, '0, -1, cyc);
      check_res("mismatch", 1'b0, 1'b1, 1'b0, 32'd2, 32'd31, 32'd30, 32'd2);

      // WAIT that never matches, TIMEOUT=10
      wr_a(0, ent(2'd0, 5'd20, 32'd7));
      rf_a[20] = 32'd6;
      run_a(1'b0, 0, '0, -1, cyc);
      chk("timeout_cycles", 32'(cyc), 32'd20);
      check_res("timeout", 1'b0, 1'b1, 1'b1, 32'd0, 32'd6, 32'd7, 32'd0);

      // Full table of matching CHECKs, no END
      for (int i = 0; i < DEPTH; i++) begin
         wr_a(i, ent(2'd1, 5'(i + 1), 32'(i * 3 + 5)));
         rf_a[i + 1] = 32'(i * 3 + 5);
      end
      run_a(1'b0, 0, '0, -1, cyc);
      chk("full_cycles", 32'(cyc), 32'd32);
      check_res("full", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd16);

      // Start pulse and table write mid-run are both ignored
      run_a(1'b0, 0, '0, 7, cyc);
      chk("midrun_cycles", 32'(cyc), 32'd32);
      check_res("midrun", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd16);
      run_a(1'b0, 0, '0, -1, cyc);
      check_res("rerun", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd16);

      // Asynchronous reset in the middle of a run
      @(negedge clk);
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre_rst_busy", 32'(bus_a.busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      run_a(1'b0, 0, '0, -1, cyc);
      chk("postrst_cycles", 32'(cyc), 32'd32);
      check_res("postrst", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd16);

      // TIMEOUT=0: WAIT polls until the register changes after 500 cycles
      rf_b[20] = 32'd6;
      @(negedge clk);
      bus_b.cfg_we = 1'b1; bus_b.cfg_addr = 4'd0; bus_b.cfg_data = ent(2'd0, 5'd20, 32'd7);
      @(negedge clk);
      bus_b.cfg_addr = 4'd1; bus_b.cfg_data = ent(2'd2, 5'd0, 32'd0);
      @(negedge clk);
      bus_b.cfg_we = 1'b0;
      bus_b.start  = 1'b1;
      @(negedge clk);
      bus_b.start  = 1'b0;
      cyc = 1;
      while (bus_b.done !== 1'b1 && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         if (cyc == 500) begin
            chk("nto_busy_500", 32'(bus_b.busy), 32'd1);
            rf_b[20] = 32'd7;
         end
      end
      chk("nto_done", 32'(bus_b.done), 32'd1);
      chk("nto_pass", 32'(bus_b.pass), 32'd1);
      chk("nto_timeout", 32'(bus_b.timeout), 32'd0);
      chk("nto_late", 32'(cyc > 500), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
